imm_gen_pipe: RTL and testbench
===============================

Name: imm_gen_pipe

Overview:
Parametrised, pipelined immediate generator for the decode stage. It covers all RV32I/RV64I immediate formats (I, S, B, U, J, shift-amount, CSR-zimm) and reports the decoded format and an illegal-opcode flag. A two-entry skid buffer with valid/ready handshakes sits on both sides, so decode can be stalled or flushed without losing or duplicating instructions.

Parameters:
XLEN, 64, datapath width; legal values 32 or 64; sets the sign-extension width and the shamt width (5 bits for 32, 6 bits for 64).
SHAMT_ZEXT, 1, 1 = OP-IMM/OP-IMM-32 shifts produce a zero-extended shamt; 0 = plain I-type.

Ports:
clk  in  1  clock; all state updates on rising edge.
reset_n  in  1  asynchronous, active-low reset.
flush  in  1  synchronous; drops all buffered entries.
in_valid  in  1  upstream has an instruction.
in_ready  out  1  block can accept this cycle.
in_inst  in  32  instruction word.
out_valid  out  1  out_imm/out_fmt/out_illegal are valid.
out_ready  in  1  downstream consumes this cycle.
out_imm  out  XLEN  sign- or zero-extended immediate.
out_fmt  out  3  format code (package enum).
out_illegal  out  1  opcode not in the supported set.

Behaviour:
- Reset (reset_n=0, async): both entries invalid; out_valid=0, in_ready=1, out_imm=0, out_fmt=FMT_R, out_illegal=0. in_ready is 1 after the first clock edge once reset_n is deasserted.
- Transfer rules:
  - Input accepted when in_valid & in_ready.
  - Output consumed when out_valid & out_ready.
  - Latency: an instruction accepted in cycle N appears on the outputs in cycle N+1 at the earliest.
- Storage: output register (entry 0) plus skid register (entry 1).
  - in_ready is registered and equals "skid entry empty", so there is no combinational path from out_ready to in_ready.
  - Accept while entry 0 is empty or being consumed: the result goes to entry 0.
  - Accept while entry 0 is held: the result goes to the skid entry, and in_ready drops next cycle.
  - Consume with skid full: skid moves to entry 0, and in_ready rises next cycle.
  - Simultaneous accept and consume with skid full cannot occur, because in_ready=0 in that case.
  - Order is strictly FIFO.
- While out_valid=1 and out_ready=0, out_imm, out_fmt and out_illegal hold stable.
- flush has priority over accept and consume in the same cycle: both entries are invalidated, the input that cycle is discarded, and in_ready=1 next cycle.
- Decode, combinational on in_inst and registered at accept, keyed on opcode in_inst[6:0]:
  - 0000011, 0010011, 0011011, 1100111 → FMT_I: sext(inst[31:20]).
  - 0010011/0011011 with funct3 001/101 and SHAMT_ZEXT=1 → FMT_SH: zext(inst[25:20]) for XLEN=64, zext(inst[24:20]) for XLEN=32 or opcode 0011011. inst[30] (arith bit) is ignored.
  - 0100011 → FMT_S: sext({inst[31:25],inst[11:7]}).
  - 1100011 → FMT_B: sext({inst[31],inst[7],inst[30:25],inst[11:8],1'b0}).
  - 0110111, 0010111 → FMT_U: sext({inst[31:12],12'b0}); for XLEN=64, bits 63:32 copy inst[31].
  - 1101111 → FMT_J: sext({inst[31],inst[19:12],inst[20],inst[30:21],1'b0}).
  - 1110011 → FMT_Z: funct3[2]=1 gives zext(inst[19:15]); otherwise sext(inst[31:20]).
  - 0110011, 0111011 → FMT_R: imm=0.
  - Any other opcode → imm=0, fmt=FMT_R, illegal=1.
- The illegal flag only reports; the entry still flows through the pipeline normally.

Decomposition:
- Package imm_gen_pkg holds the opcode localparams (OPC_LOAD, OPC_OP_IMM, OPC_OP_IMM32, OPC_JALR, OPC_STORE, OPC_BRANCH, OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_SYSTEM, OPC_OP, OPC_OP32) and the 3-bit fmt enum (FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J, FMT_SH, FMT_Z).
- Sub-module imm_decode_comb holds the pure combinational decode (inst → imm, fmt, illegal).
- The top level holds the skid-buffer control and registers.

Test Plan:
- XLEN=64; 0xFFF00093 (addi x1,x0,-1) → next cycle out_imm=0xFFFFFFFFFFFFFFFF, fmt=FMT_I, illegal=0.
- Sequence with out_ready=1:
  - 0xFE512E23 (sw) → 0xFFFFFFFFFFFFFFFC, FMT_S.
  - 0xFE000CE3 (beq -8) → 0xFFFFFFFFFFFFFFF8, FMT_B.
  - 0x001000EF (jal +2048) → 0x800, FMT_J.
- 0x123450B7 → 0x0000000012345000; 0x800000B7 → 0xFFFFFFFF80000000. With XLEN=32, 0x800000B7 → 0x80000000.
- Shifts: 0x03F09093 (slli 63) and 0x43F0D093 (srai 63) → out_imm=0x3F, FMT_SH. With SHAMT_ZEXT=0, srai → 0x43F, FMT_I.
- Backpressure: stream A,B,C with out_ready=0 for 3 cycles → A and B accepted, in_ready=0 while C is held upstream. Then out_ready=1 → A, B, C emitted in order with no drop or duplicate. Repeat with flush while full → out_valid=0 and in_ready=1 next cycle.
- Illegal opcode 0x0000007F → imm=0, illegal=1. Assert reset_n=0 mid-stream with out_valid=1 → out_valid=0 immediately (asynchronous); after release, the first accepted instruction decodes correctly.

Source files
------------

// File: rtl/imm_gen_pkg.sv
// -----------------------------------------------------------------------------
// imm_gen_pkg
// Shared definitions for the decode-stage immediate generator:
//   - RV32I/RV64I major opcodes recognised by the decoder
//   - fmt_e : 3-bit immediate format code reported alongside the immediate
//   - sext12: 12-bit to 32-bit sign extension used by several formats
// -----------------------------------------------------------------------------
package imm_gen_pkg;

    // Major opcodes (inst[6:0])
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_OP_IMM32 = 7'b0011011;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_OP32     = 7'b0111011;

    // Immediate format reported with each decoded instruction.
    // FMT_R doubles as "no immediate" (R-type and illegal opcodes).
    typedef enum logic [2:0] {
        FMT_R  = 3'd0,
        FMT_I  = 3'd1,
        FMT_S  = 3'd2,
        FMT_B  = 3'd3,
        FMT_U  = 3'd4,
        FMT_J  = 3'd5,
        FMT_SH = 3'd6,
        FMT_Z  = 3'd7
    } fmt_e;

    // Sign-extend a 12-bit field to 32 bits.
    function automatic logic [31:0] sext12(input logic [11:0] v);
        return {{20{v[11]}}, v};
    endfunction

endpackage : imm_gen_pkg

// File: rtl/imm_decode_comb.sv
// -----------------------------------------------------------------------------
// imm_decode_comb
// Pure combinational immediate decode: instruction word -> immediate, format
// code and illegal-opcode flag.
//
// Parameters:
//   XLEN       : 32 or 64, width of the produced immediate
//   SHAMT_ZEXT : 1 = OP-IMM/OP-IMM-32 shifts yield a zero-extended shamt
//
// Ports:
//   i_inst    in   32    instruction word
//   o_imm     out  XLEN  sign- or zero-extended immediate
//   o_fmt     out  3     format code (fmt_e)
//   o_illegal out  1     opcode not in the supported set
// -----------------------------------------------------------------------------
module imm_decode_comb
    import imm_gen_pkg::*;
#(
    parameter int XLEN       = 64,
    parameter bit SHAMT_ZEXT = 1'b1
) (
    input  logic [31:0]     i_inst,
    output logic [XLEN-1:0] o_imm,
    output fmt_e            o_fmt,
    output logic            o_illegal
);

    logic [6:0]        w_opc;
    logic [2:0]        w_funct3;
    // Every immediate fits in 32 bits. Zero-extended formats keep bit 31
    // clear, so a single signed widening below serves both extension kinds.
    logic signed [31:0] w_imm32;

    assign w_opc    = i_inst[6:0];
    assign w_funct3 = i_inst[14:12];

    always_comb begin
        w_imm32   = '0;
        o_fmt     = FMT_R;
        o_illegal = 1'b0;

        case (w_opc)
            OPC_LOAD, OPC_JALR: begin
                o_fmt   = FMT_I;
                w_imm32 = sext12(i_inst[31:20]);
            end

            OPC_OP_IMM, OPC_OP_IMM32: begin
                // funct3 001 (SLLI) and 101 (SRLI/SRAI) are the only OP-IMM
                // encodings whose low funct3 bits are 01. inst[30] (the
                // arithmetic select) is deliberately left out of the shamt.
                if (SHAMT_ZEXT && (w_funct3[1:0] == 2'b01)) begin
                    o_fmt = FMT_SH;
                    if ((XLEN == 64) && (w_opc == OPC_OP_IMM)) begin
                        w_imm32 = {26'b0, i_inst[25:20]};
                    end else begin
                        w_imm32 = {27'b0, i_inst[24:20]};
                    end
                end else begin
                    o_fmt   = FMT_I;
                    w_imm32 = sext12(i_inst[31:20]);
                end
            end

            OPC_STORE: begin
                o_fmt   = FMT_S;
                w_imm32 = sext12({i_inst[31:25], i_inst[11:7]});
            end

            OPC_BRANCH: begin
                o_fmt   = FMT_B;
                w_imm32 = {{19{i_inst[31]}}, i_inst[31], i_inst[7],
                           i_inst[30:25], i_inst[11:8], 1'b0};
            end

            OPC_LUI, OPC_AUIPC: begin
                o_fmt   = FMT_U;
                w_imm32 = {i_inst[31:12], 12'b0};
            end

            OPC_JAL: begin
                o_fmt   = FMT_J;
                w_imm32 = {{11{i_inst[31]}}, i_inst[31], i_inst[19:12],
                           i_inst[20], i_inst[30:21], 1'b0};
            end

            OPC_SYSTEM: begin
                // funct3[2] selects the CSR*I forms carrying a 5-bit zimm
                // in the rs1 field; the other forms carry the CSR address.
                o_fmt = FMT_Z;
                if (w_funct3[2]) begin
                    w_imm32 = {27'b0, i_inst[19:15]};
                end else begin
                    w_imm32 = sext12(i_inst[31:20]);
                end
            end

            OPC_OP, OPC_OP32: begin
                o_fmt   = FMT_R;
                w_imm32 = '0;
            end

            default: begin
                o_fmt     = FMT_R;
                w_imm32   = '0;
                o_illegal = 1'b1;
            end
        endcase
    end

    // Signed widening: sign-extends to 64 bits, identity for XLEN=32.
    assign o_imm = XLEN'(w_imm32);

endmodule : imm_decode_comb

// File: rtl/imm_gen_pipe.sv
// -----------------------------------------------------------------------------
// imm_gen_pipe
// Pipelined immediate generator for the decode stage. The instruction is
// decoded combinationally on the way in and the result is captured into a
// two-entry skid buffer (output register + skid register) with valid/ready
// handshakes on both sides.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both 1 on that interface; valid never depends on ready, and once
// out_valid is raised the output payload holds until out_ready is seen.
//
// Parameters:
//   XLEN       : 32 or 64
//   SHAMT_ZEXT : 1 = shifts report a zero-extended shamt (FMT_SH)
//
// Ports:
//   clk          in   1     clock, rising edge
//   reset_n      in   1     asynchronous active-low reset
//   flush        in   1     synchronous, drops all buffered entries
//   in_valid     in   1     upstream has an instruction
//   in_ready     out  1     block can accept this cycle (registered)
//   in_inst      in   32    instruction word
//   out_valid    out  1     out_imm/out_fmt/out_illegal are valid
//   out_ready    in   1     downstream consumes this cycle
//   out_imm      out  XLEN  decoded immediate
//   out_fmt      out  3     format code (fmt_e)
//   out_illegal  out  1     opcode not in the supported set
// -----------------------------------------------------------------------------
module imm_gen_pipe
    import imm_gen_pkg::*;
#(
    parameter int XLEN       = 64,
    parameter bit SHAMT_ZEXT = 1'b1
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_inst,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_imm,
    output logic [2:0]      out_fmt,
    output logic            out_illegal
);

    // Decoder result for the instruction currently on in_inst
    logic [XLEN-1:0] w_dec_imm;
    fmt_e            w_dec_fmt;
    logic            w_dec_illegal;

    // Entry 0: output register
    logic            r_valid0;
    logic [XLEN-1:0] r_imm0;
    fmt_e            r_fmt0;
    logic            r_illegal0;

    // Entry 1: skid register
    logic            r_valid1;
    logic [XLEN-1:0] r_imm1;
    fmt_e            r_fmt1;
    logic            r_illegal1;

    // Handshake and next-state controls
    logic w_accept;
    logic w_consume;
    logic w_valid0_nxt;
    logic w_valid1_nxt;
    logic w_ld0_new;     // entry 0 <- decoder
    logic w_ld0_skid;    // entry 0 <- entry 1
    logic w_ld1_new;     // entry 1 <- decoder

    imm_decode_comb #(
        .XLEN       (XLEN),
        .SHAMT_ZEXT (SHAMT_ZEXT)
    ) u_decode (
        .i_inst    (in_inst),
        .o_imm     (w_dec_imm),
        .o_fmt     (w_dec_fmt),
        .o_illegal (w_dec_illegal)
    );

    // in_ready is simply "skid empty". r_valid1 is a flop, so there is no
    // combinational path from out_ready to in_ready.
    assign in_ready  = ~r_valid1;
    assign out_valid = r_valid0;

    assign w_accept  = in_valid & in_ready;
    assign w_consume = r_valid0 & out_ready;

    always_comb begin
        w_valid0_nxt = r_valid0;
        w_valid1_nxt = r_valid1;
        w_ld0_new    = 1'b0;
        w_ld0_skid   = 1'b0;
        w_ld1_new    = 1'b0;

        if (flush) begin
            // Flush wins over accept and consume; the input is dropped.
            w_valid0_nxt = 1'b0;
            w_valid1_nxt = 1'b0;
        end else if (w_consume) begin
            if (r_valid1) begin
                // Skid full implies in_ready=0, so no accept can coincide.
                w_ld0_skid   = 1'b1;
                w_valid1_nxt = 1'b0;
            end else if (w_accept) begin
                w_ld0_new    = 1'b1;
            end else begin
                w_valid0_nxt = 1'b0;
            end
        end else if (w_accept) begin
            if (!r_valid0) begin
                w_ld0_new    = 1'b1;
                w_valid0_nxt = 1'b1;
            end else begin
                // Entry 0 is being held by the consumer: park in the skid.
                w_ld1_new    = 1'b1;
                w_valid1_nxt = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_valid0 <= 1'b0;
            r_valid1 <= 1'b0;
        end else begin
            r_valid0 <= w_valid0_nxt;
            r_valid1 <= w_valid1_nxt;
        end
    end

    // Entry 0 payload only moves when it is empty or being consumed, so the
    // outputs stay stable while out_valid=1 and out_ready=0.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_imm0     <= '0;
            r_fmt0     <= FMT_R;
            r_illegal0 <= 1'b0;
        end else if (w_ld0_new) begin
            r_imm0     <= w_dec_imm;
            r_fmt0     <= w_dec_fmt;
            r_illegal0 <= w_dec_illegal;
        end else if (w_ld0_skid) begin
            r_imm0     <= r_imm1;
            r_fmt0     <= r_fmt1;
            r_illegal0 <= r_illegal1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_imm1     <= '0;
            r_fmt1     <= FMT_R;
            r_illegal1 <= 1'b0;
        end else if (w_ld1_new) begin
            r_imm1     <= w_dec_imm;
            r_fmt1     <= w_dec_fmt;
            r_illegal1 <= w_dec_illegal;
        end
    end

    assign out_imm     = r_imm0;
    assign out_fmt     = r_fmt0;
    assign out_illegal = r_illegal0;

endmodule : imm_gen_pipe

// File: tb/tb_imm_gen_pipe.sv
module tb_imm_gen_pipe;
    import imm_gen_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n;
    logic        flush;
    logic        in_valid;
    logic [31:0] in_inst;
    logic        out_ready;

    // XLEN=64, SHAMT_ZEXT=1 (main DUT)
    logic        in_ready;
    logic        out_valid;
    logic [63:0] out_imm;
    logic [2:0]  out_fmt;
    logic        out_illegal;

    // XLEN=32, SHAMT_ZEXT=1
    logic        in_ready_32;
    logic        out_valid_32;
    logic [31:0] out_imm_32;
    logic [2:0]  out_fmt_32;
    logic        out_illegal_32;

    // XLEN=64, SHAMT_ZEXT=0
    logic        in_ready_nz;
    logic        out_valid_nz;
    logic [63:0] out_imm_nz;
    logic [2:0]  out_fmt_nz;
    logic        out_illegal_nz;

    imm_gen_pipe #(.XLEN(64), .SHAMT_ZEXT(1'b1)) dut (
        .clk(clk), .reset_n(reset_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_imm(out_imm), .out_fmt(out_fmt), .out_illegal(out_illegal)
    );

    imm_gen_pipe #(.XLEN(32), .SHAMT_ZEXT(1'b1)) dut32 (
        .clk(clk), .reset_n(reset_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready_32), .in_inst(in_inst),
        .out_valid(out_valid_32), .out_ready(1'b1),
        .out_imm(out_imm_32), .out_fmt(out_fmt_32), .out_illegal(out_illegal_32)
    );

    imm_gen_pipe #(.XLEN(64), .SHAMT_ZEXT(1'b0)) dut_nz (
        .clk(clk), .reset_n(reset_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready_nz), .in_inst(in_inst),
        .out_valid(out_valid_nz), .out_ready(1'b1),
        .out_imm(out_imm_nz), .out_fmt(out_fmt_nz), .out_illegal(out_illegal_nz)
    );

    // ---------------- scoreboard ----------------
    int          checks   = 0;
    int          failures = 0;
    logic [63:0] exp_q[$];

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // ---------------- directed vectors ----------------
    localparam int N = 17;
    logic [31:0] t_inst [N] = '{
        32'hFFF00093, 32'hFE512E23, 32'hFE000CE3, 32'h001000EF,
        32'h123450B7, 32'h800000B7, 32'h03F09093, 32'h43F0D093,
        32'h0000007F, 32'h340FD0F3, 32'hFFF01073, 32'h002081B3,
        32'h03F0909B, 32'h80002083, 32'h7FF08067, 32'h00001097,
        32'h8000F093
    };
    logic [63:0] t_imm [N] = '{
        64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFC, 64'hFFFFFFFFFFFFFFF8, 64'h0000000000000800,
        64'h0000000012345000, 64'hFFFFFFFF80000000, 64'h000000000000003F, 64'h000000000000003F,
        64'h0, 64'h000000000000001F, 64'hFFFFFFFFFFFFFFFF, 64'h0,
        64'h000000000000001F, 64'hFFFFFFFFFFFFF800, 64'h00000000000007FF, 64'h0000000000001000,
        64'hFFFFFFFFFFFFF800
    };
    fmt_e t_fmt [N] = '{
        FMT_I, FMT_S, FMT_B, FMT_J, FMT_U, FMT_U, FMT_SH, FMT_SH,
        FMT_R, FMT_Z, FMT_Z, FMT_R, FMT_SH, FMT_I, FMT_I, FMT_U, FMT_I
    };
    logic t_ill [N] = '{0,0,0,0,0,0,0,0,1,0,0,0,0,0,0,0,0};
    logic [31:0] t_imm32 [N] = '{
        32'hFFFFFFFF, 32'hFFFFFFFC, 32'hFFFFFFF8, 32'h00000800,
        32'h12345000, 32'h80000000, 32'h0000001F, 32'h0000001F,
        32'h0, 32'h0000001F, 32'hFFFFFFFF, 32'h0,
        32'h0000001F, 32'hFFFFF800, 32'h000007FF, 32'h00001000,
        32'hFFFFF800
    };
    fmt_e t_fmt32 [N] = '{
        FMT_I, FMT_S, FMT_B, FMT_J, FMT_U, FMT_U, FMT_SH, FMT_SH,
        FMT_R, FMT_Z, FMT_Z, FMT_R, FMT_SH, FMT_I, FMT_I, FMT_U, FMT_I
    };
    logic [63:0] t_imm_nz [N] = '{
        64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFC, 64'hFFFFFFFFFFFFFFF8, 64'h0000000000000800,
        64'h0000000012345000, 64'hFFFFFFFF80000000, 64'h000000000000003F, 64'h000000000000043F,
        64'h0, 64'h000000000000001F, 64'hFFFFFFFFFFFFFFFF, 64'h0,
        64'h000000000000003F, 64'hFFFFFFFFFFFFF800, 64'h00000000000007FF, 64'h0000000000001000,
        64'hFFFFFFFFFFFFF800
    };
    fmt_e t_fmt_nz [N] = '{
        FMT_I, FMT_S, FMT_B, FMT_J, FMT_U, FMT_U, FMT_I, FMT_I,
        FMT_R, FMT_Z, FMT_Z, FMT_R, FMT_I, FMT_I, FMT_I, FMT_U, FMT_I
    };

    localparam logic [31:0] INST_A = 32'hFFF00093;
    localparam logic [31:0] INST_B = 32'hFE512E23;
    localparam logic [31:0] INST_C = 32'h001000EF;

    // ---------------- driver tasks ----------------
    // Present one instruction for exactly one cycle (accepted if in_ready=1).
    task automatic send_one(input logic [31:0] inst);
        @(posedge clk); #1;
        in_valid = 1'b1;
        in_inst  = inst;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // Fill entry 0 with A and the skid with B, leave C waiting upstream.
    task automatic fill_abc();
        @(posedge clk); #1;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_inst   = INST_A;
        @(posedge clk); #1;
        in_inst   = INST_B;
        @(posedge clk); #1;
        in_inst   = INST_C;
    endtask

    // Drain with out_ready=1, comparing against exp_q in order.
    task automatic drain_check(input int max_cycles);
        logic take;
        for (int cyc = 0; cyc < max_cycles && (exp_q.size() > 0 || in_valid); cyc++) begin
            @(negedge clk);
            take = in_valid && in_ready;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) check("bp_extra_output", out_imm, 64'hDEADDEADDEADDEAD);
                else                   check("bp_order", out_imm, exp_q.pop_front());
            end
            @(posedge clk); #1;
            if (take) in_valid = 1'b0;
        end
        check("bp_all_drained", 64'(exp_q.size()), 64'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        reset_n   = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_inst   = 32'h0;
        out_ready = 1'b1;

        repeat (2) @(negedge clk);
        check("rst_out_valid",   64'(out_valid),   64'd0);
        check("rst_in_ready",    64'(in_ready),    64'd1);
        check("rst_out_imm",     out_imm,          64'd0);
        check("rst_out_fmt",     64'(out_fmt),     64'(FMT_R));
        check("rst_out_illegal", 64'(out_illegal), 64'd0);
        reset_n = 1'b1;

        // Back-to-back decode of every vector with out_ready=1.
        for (int i = 0; i <= N; i++) begin
            @(posedge clk); #1;
            if (i < N) begin
                in_valid = 1'b1;
                in_inst  = t_inst[i];
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            if (i > 0) begin
                check($sformatf("dec_valid[%0d]", i-1),   64'(out_valid),   64'd1);
                check($sformatf("dec_imm[%0d]", i-1),     out_imm,          t_imm[i-1]);
                check($sformatf("dec_fmt[%0d]", i-1),     64'(out_fmt),     64'(t_fmt[i-1]));
                check($sformatf("dec_illegal[%0d]", i-1), 64'(out_illegal), 64'(t_ill[i-1]));
                check($sformatf("dec32_imm[%0d]", i-1),   64'(out_imm_32),  64'(t_imm32[i-1]));
                check($sformatf("dec32_fmt[%0d]", i-1),   64'(out_fmt_32),  64'(t_fmt32[i-1]));
                check($sformatf("decnz_imm[%0d]", i-1),   out_imm_nz,       t_imm_nz[i-1]);
                check($sformatf("decnz_fmt[%0d]", i-1),   64'(out_fmt_nz),  64'(t_fmt_nz[i-1]));
            end
        end
        @(negedge clk);
        check("idle_out_valid", 64'(out_valid), 64'd0);

        // Backpressure: A in entry 0, B in skid, C held upstream.
        fill_abc();
        @(negedge clk);
        check("bp_in_ready_low", 64'(in_ready),  64'd0);
        check("bp_out_valid",    64'(out_valid), 64'd1);
        check("bp_hold_imm",     out_imm,        64'hFFFFFFFFFFFFFFFF);
        @(posedge clk);
        @(negedge clk);
        check("bp_hold_imm2",    out_imm,        64'hFFFFFFFFFFFFFFFF);
        check("bp_hold_fmt2",    64'(out_fmt),   64'(FMT_I));
        check("bp_in_ready_low2", 64'(in_ready), 64'd0);
        exp_q.push_back(64'hFFFFFFFFFFFFFFFF);
        exp_q.push_back(64'hFFFFFFFFFFFFFFFC);
        exp_q.push_back(64'h0000000000000800);
        @(posedge clk); #1;
        out_ready = 1'b1;
        drain_check(20);
        @(negedge clk);
        check("bp_no_duplicate", 64'(out_valid), 64'd0);
        check("bp_in_ready_back", 64'(in_ready), 64'd1);

        // Flush while full: everything dropped, C discarded.
        fill_abc();
        @(posedge clk); #1;
        flush = 1'b1;
        @(posedge clk); #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check("flush_out_valid", 64'(out_valid), 64'd0);
        check("flush_in_ready",  64'(in_ready),  64'd1);
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(negedge clk);
        check("flush_stays_empty", 64'(out_valid), 64'd0);

        // Flush on an empty pipe with a valid input: the input is dropped.
        @(posedge clk); #1;
        in_valid = 1'b1;
        in_inst  = 32'h00001097;
        flush    = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        flush    = 1'b0;
        @(negedge clk);
        check("flush_drops_input", 64'(out_valid), 64'd0);

        // Pipeline still works after flush.
        send_one(32'h00001097);
        @(negedge clk);
        check("post_flush_valid", 64'(out_valid), 64'd1);
        check("post_flush_imm",   out_imm,         64'h1000);
        check("post_flush_fmt",   64'(out_fmt),    64'(FMT_U));

        // Asynchronous reset with out_valid=1.
        @(posedge clk); #1;
        out_ready = 1'b0;
        send_one(INST_B);
        @(negedge clk);
        check("pre_rst_valid", 64'(out_valid), 64'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_rst_valid",   64'(out_valid),   64'd0);
        check("async_rst_imm",     out_imm,          64'd0);
        check("async_rst_fmt",     64'(out_fmt),     64'(FMT_R));
        check("async_rst_in_ready", 64'(in_ready),   64'd1);
        @(negedge clk);
        reset_n   = 1'b1;
        out_ready = 1'b1;
        send_one(32'h123450B7);
        @(negedge clk);
        check("post_rst_valid",   64'(out_valid),   64'd1);
        check("post_rst_imm",     out_imm,          64'h0000000012345000);
        check("post_rst_fmt",     64'(out_fmt),     64'(FMT_U));
        check("post_rst_illegal", 64'(out_illegal), 64'd0);

        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global time bound.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule : tb_imm_gen_pipe
